// File: rtl/mlvds_rx_pkg.sv
// Shared M-LVDS link constants, FSM encoding and CRC-CCITT helper.
package mlvds_rx_pkg;

   localparam logic [7:0]  MLVDS_PREAMBLE = 8'h16;
   localparam logic [4:0]  MLVDS_BCAST    = 5'h1F;
   localparam int unsigned MLVDS_MAX_LEN  = 512;
   localparam int unsigned MLVDS_TIMEOUT  = 64;
   localparam logic [15:0] CRC_INIT       = 16'hFFFF;
   localparam logic [15:0] CRC_POLY       = 16'h1021;

   typedef enum logic [3:0] {
      ST_HUNT   = 4'd0,
      ST_LEN_HI = 4'd1,
      ST_LEN_LO = 4'd2,
      ST_ADDR   = 4'd3,
      ST_FRAME  = 4'd4,
      ST_CRC_HI = 4'd5,
      ST_CRC_LO = 4'd6,
      ST_CHECK  = 4'd7,
      ST_DRAIN  = 4'd8
   } mlvds_state_e;

   // CRC-CCITT (poly 0x1021), one byte folded in MSB first
   function automatic logic [15:0] crc_ccitt(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] v;
      v = crc;
      for (int unsigned i = 0; i < 8; i++) begin
         if (v[15] ^ data[3'(7 - i)]) v = {v[14:0], 1'b0} ^ CRC_POLY;
         else                         v = {v[14:0], 1'b0};
      end
      return v;
   endfunction

endpackage

// File: rtl/fifo_512x8.sv
// Payload buffer: 512x8 FIFO with registered read data and synchronous flush.
module fifo_512x8 #(
   parameter int unsigned DEPTH = 512,
   parameter int unsigned W     = 8
) (
   input  logic         c,
   input  logic         rst_n,
   input  logic         i_flush,
   input  logic         i_wr_en,
   input  logic [W-1:0] i_wr_data,
   input  logic         i_rd_en,
   output logic [W-1:0] o_rd_data,
   output logic         o_empty_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [W-1:0]  r_rd_data;
   logic          w_do_wr, w_do_rd;

   assign o_empty_c = (r_count == '0);
   assign w_do_wr   = i_wr_en && !i_flush && (r_count != CW'(DEPTH));
   assign w_do_rd   = i_rd_en && !i_flush && !o_empty_c;
   assign o_rd_data = r_rd_data;

   // Storage array, no reset needed
   always_ff @(posedge c) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers, occupancy and registered read data
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_rd_data <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_rd) begin
            r_rd_ptr  <= r_rd_ptr + AW'(1);
            r_rd_data <= r_mem[r_rd_ptr];
         end
         r_count <= r_count + CW'(w_do_wr) - CW'(w_do_rd);
      end
   end

endmodule

// File: rtl/mlvds_rx_deser.sv
// Line front end: synchronizers, bit-clock edge detect, dibit/byte assembly, preamble hunt.
module mlvds_rx_deser
   import mlvds_rx_pkg::*;
(
   input  logic       c,
   input  logic       rst_n,
   input  logic [2:0] i_line,
   input  logic       i_hunt,
   output logic [7:0] o_byte,
   output logic       o_byte_dv,
   output logic       o_edge_seen_c
);

   logic [2:0] r_s1, r_s2, r_s3;
   logic       r_clk_d;
   logic [7:0] r_window, r_acc, r_byte;
   logic [1:0] r_cnt;
   logic       r_byte_dv;
   logic [1:0] w_dibit;
   logic [7:0] w_window, w_acc;

   assign o_edge_seen_c = r_s3[0] ^ r_clk_d;
   assign w_dibit       = r_s3[2:1];
   assign w_window      = {r_window[5:0], w_dibit};
   assign w_acc         = {r_acc[5:0], w_dibit};
   assign o_byte        = r_byte;
   assign o_byte_dv     = r_byte_dv;

   // Three-flop synchronizers on clock and both data lanes, plus edge history
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_s3    <= '0;
         r_clk_d <= 1'b0;
      end else begin
         r_s1    <= i_line;
         r_s2    <= r_s1;
         r_s3    <= r_s2;
         r_clk_d <= r_s3[0];
      end
   end

   // Each bit-clock edge yields a dibit: hunt for preamble, else pack 4 dibits per byte
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_window  <= '0;
         r_acc     <= '0;
         r_byte    <= '0;
         r_cnt     <= '0;
         r_byte_dv <= 1'b0;
      end else begin
         r_byte_dv <= 1'b0;
         if (o_edge_seen_c) begin
            r_window <= w_window;
            if (i_hunt) begin
               r_cnt <= '0;
               if (w_window == MLVDS_PREAMBLE) begin
                  r_byte    <= w_window;
                  r_byte_dv <= 1'b1;
               end
            end else begin
               r_acc <= w_acc;
               r_cnt <= r_cnt + 2'd1;
               if (r_cnt == 2'd3) begin
                  r_byte    <= w_acc;
                  r_byte_dv <= 1'b1;
               end
            end
         end else if (i_hunt) begin
            r_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/mlvds_rx.sv
// M-LVDS receiver: frame parser, CRC/address check, payload buffering and drain.
module mlvds_rx
   import mlvds_rx_pkg::*;
#(
   parameter int unsigned TIMEOUT = MLVDS_TIMEOUT
) (
   input  logic       c,
   input  logic       rst_n,
   input  logic [4:0] mcb_addr,
   input  logic [2:0] mlvds_ro,
   output logic [7:0] rxd,
   output logic       rxdv,
   output logic       rx_active,
   output logic       crc_err,
   output logic       drop
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
   localparam int unsigned CNT_W  = $clog2(MLVDS_MAX_LEN);

   mlvds_state_e      r_state, w_next;
   logic [7:0]        w_byte;
   logic              w_byte_dv, w_edge, w_hunt;
   logic [7:0]        r_len_hi;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_addr_ok;
   logic [15:0]       r_crc, r_crc_rx;
   logic [IDLE_W-1:0] r_idle;
   logic              r_rxdv, r_rx_active, r_crc_err, r_drop;
   logic [15:0]       w_len;
   logic              w_len_bad, w_timeout, w_crc_ok, w_fifo_empty;
   logic              w_drop_c, w_crc_err_c, w_wr_en, w_rd_en, w_flush, w_frame_end;

   assign w_hunt    = (r_state == ST_HUNT);
   assign w_len     = {r_len_hi, w_byte};
   assign w_len_bad = (w_len == 16'd0) || (w_len > 16'(MLVDS_MAX_LEN));
   assign w_crc_ok  = (r_crc_rx == r_crc);
   assign w_timeout = (r_idle >= IDLE_W'(TIMEOUT)) && (r_state != ST_HUNT) && (r_state != ST_DRAIN);

   assign rxdv      = r_rxdv;
   assign rx_active = r_rx_active;
   assign crc_err   = r_crc_err;
   assign drop      = r_drop;

   mlvds_rx_deser u_deser (
      .c             (c),
      .rst_n         (rst_n),
      .i_line        (mlvds_ro),
      .i_hunt        (w_hunt),
      .o_byte        (w_byte),
      .o_byte_dv     (w_byte_dv),
      .o_edge_seen_c (w_edge)
   );

   fifo_512x8 u_fifo (
      .c         (c),
      .rst_n     (rst_n),
      .i_flush   (w_flush),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_byte),
      .i_rd_en   (w_rd_en),
      .o_rd_data (rxd),
      .o_empty_c (w_fifo_empty)
   );

   // FSM state register
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) r_state <= ST_HUNT;
      else        r_state <= w_next;
   end

   // FSM next state
   always_comb begin
      w_next = r_state;
      if (w_timeout) begin
         w_next = ST_HUNT;
      end else begin
         case (r_state)
            ST_HUNT:   if (w_byte_dv && (w_byte == MLVDS_PREAMBLE)) w_next = ST_LEN_HI;
            ST_LEN_HI: if (w_byte_dv) w_next = ST_LEN_LO;
            ST_LEN_LO: if (w_byte_dv) begin
                          if (w_len_bad) w_next = ST_HUNT;
                          else           w_next = ST_ADDR;
                       end
            ST_ADDR:   if (w_byte_dv) begin
                          if (r_cnt == '0) w_next = ST_CRC_HI;
                          else             w_next = ST_FRAME;
                       end
            ST_FRAME:  if (w_byte_dv && (r_cnt == CNT_W'(1))) w_next = ST_CRC_HI;
            ST_CRC_HI: if (w_byte_dv) w_next = ST_CRC_LO;
            ST_CRC_LO: if (w_byte_dv) w_next = ST_CHECK;
            ST_CHECK:  begin
                          if (r_addr_ok && w_crc_ok) w_next = ST_DRAIN;
                          else                       w_next = ST_HUNT;
                       end
            ST_DRAIN:  if (w_fifo_empty) w_next = ST_HUNT;
            default:   w_next = ST_HUNT;
         endcase
      end
   end

   // FSM outputs: fifo control and frame verdict strobes
   always_comb begin
      w_drop_c    = 1'b0;
      w_crc_err_c = 1'b0;
      w_wr_en     = 1'b0;
      w_rd_en     = 1'b0;
      w_frame_end = 1'b0;
      if (w_timeout) begin
         w_drop_c = 1'b1;
      end else begin
         case (r_state)
            ST_LEN_LO: w_drop_c = w_byte_dv && w_len_bad;
            ST_FRAME:  w_wr_en  = w_byte_dv;
            ST_CHECK:  begin
                          w_drop_c    = !r_addr_ok;
                          w_crc_err_c = r_addr_ok && !w_crc_ok;
                          w_rd_en     = r_addr_ok && w_crc_ok;
                       end
            ST_DRAIN:  begin
                          w_rd_en     = 1'b1;
                          w_frame_end = w_fifo_empty;
                       end
            default:   ;
         endcase
      end
      w_flush = w_drop_c || w_crc_err_c;
   end

   // Frame datapath: length, address verdict, running and received CRC, line idle timer
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_len_hi  <= '0;
         r_cnt     <= '0;
         r_addr_ok <= 1'b0;
         r_crc     <= CRC_INIT;
         r_crc_rx  <= '0;
         r_idle    <= '0;
      end else begin
         if (w_edge)                         r_idle <= '0;
         else if (r_idle < IDLE_W'(TIMEOUT)) r_idle <= r_idle + IDLE_W'(1);
         case (r_state)
            ST_HUNT:   r_crc <= CRC_INIT;
            ST_LEN_HI: if (w_byte_dv) begin
                          r_len_hi <= w_byte;
                          r_crc    <= crc_ccitt(r_crc, w_byte);
                       end
            ST_LEN_LO: if (w_byte_dv) begin
                          r_cnt <= CNT_W'(w_len - 16'd1);
                          r_crc <= crc_ccitt(r_crc, w_byte);
                       end
            ST_ADDR:   if (w_byte_dv) begin
                          r_addr_ok <= (w_byte[7:5] == 3'd0) &&
                                       ((w_byte[4:0] == mcb_addr) || (w_byte[4:0] == MLVDS_BCAST));
                          r_crc     <= crc_ccitt(r_crc, w_byte);
                       end
            ST_FRAME:  if (w_byte_dv) begin
                          r_cnt <= r_cnt - CNT_W'(1);
                          r_crc <= crc_ccitt(r_crc, w_byte);
                       end
            ST_CRC_HI: if (w_byte_dv) r_crc_rx[15:8] <= w_byte;
            ST_CRC_LO: if (w_byte_dv) r_crc_rx[7:0]  <= w_byte;
            default:   ;
         endcase
      end
   end

   // Registered outputs; rx_active follows line edges and clears at frame end or idle
   always_ff @(posedge c or negedge rst_n) begin
      if (!rst_n) begin
         r_rxdv      <= 1'b0;
         r_crc_err   <= 1'b0;
         r_drop      <= 1'b0;
         r_rx_active <= 1'b0;
      end else begin
         r_rxdv    <= w_rd_en && !w_fifo_empty;
         r_crc_err <= w_crc_err_c;
         r_drop    <= w_drop_c;
         if (w_drop_c || w_crc_err_c || w_frame_end)               r_rx_active <= 1'b0;
         else if (w_edge)                                          r_rx_active <= 1'b1;
         else if (w_hunt && (r_idle >= IDLE_W'(TIMEOUT)))          r_rx_active <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mlvds_rx.sv
// Scoreboard bench for mlvds_rx: transmitter model drives the line, monitor checks outputs.
module tb_mlvds_rx;

   typedef logic [7:0] u8_t;

   logic       c = 1'b0;
   logic       rst_n;
   logic [4:0] mcb_addr;
   logic [2:0] mlvds_ro;
   logic [7:0] rxd;
   logic       rxdv, rx_active, crc_err, drop;

   int   n_checks = 0;
   int   n_err    = 0;
   int   n_drop   = 0;
   int   n_crc    = 0;
   int   run_len  = 0;
   u8_t  exp_q[$];
   int   run_q[$];
   u8_t  tx_pl[$];

   always #5 c = ~c;

   mlvds_rx dut (
      .c         (c),
      .rst_n     (rst_n),
      .mcb_addr  (mcb_addr),
      .mlvds_ro  (mlvds_ro),
      .rxd       (rxd),
      .rxdv      (rxdv),
      .rx_active (rx_active),
      .crc_err   (crc_err),
      .drop      (drop)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expected bytes on rxdv, checks burst length, counts verdict pulses
   always @(negedge c) begin : monitor
      u8_t e;
      int  r;
      if (rst_n) begin
         if (rxdv) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL rxd_unexpected: got %02h with nothing expected at %0t", rxd, $time);
            end else begin
               e = exp_q.pop_front();
               check("rxd", 32'(rxd), 32'(e));
            end
            run_len++;
         end else if (run_len > 0) begin
            if (run_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL rxdv_run_unexpected: got burst of %0d at %0t", run_len, $time);
            end else begin
               r = run_q.pop_front();
               check("rxdv_run", 32'(run_len), 32'(r));
            end
            run_len = 0;
         end
         if (drop)    n_drop++;
         if (crc_err) n_crc++;
      end else begin
         run_len = 0;
      end
   end

   // One bit-clock edge carrying a dibit, then a jittered 4..5 cycle gap
   task automatic tx_dibit(input logic [1:0] d, input logic ck);
      mlvds_ro = {d, ck};
      repeat ($urandom_range(5, 4)) @(negedge c);
   endtask

   task automatic tx_byte(input u8_t b);
      tx_dibit(b[7:6], 1'b1);
      tx_dibit(b[5:4], 1'b0);
      tx_dibit(b[3:2], 1'b1);
      tx_dibit(b[1:0], 1'b0);
   endtask

   // Transmitter model: warmup, preamble, then up to 'limit' frame bytes (negative = all)
   task automatic send_frame(input u8_t addr, input logic [15:0] len, input bit flip, input int limit);
      u8_t         all[$];
      logic [15:0] crc;
      logic        fb;
      all = {};
      all.push_back(len[15:8]);
      all.push_back(len[7:0]);
      all.push_back(addr);
      foreach (tx_pl[k]) all.push_back(tx_pl[k]);
      crc = 16'hFFFF;
      foreach (all[k]) begin
         for (int i = 7; i >= 0; i--) begin
            fb  = crc[15] ^ all[k][i];
            crc = {crc[14:0], 1'b0};
            if (fb) crc = crc ^ 16'h1021;
         end
      end
      if (flip) crc[0] = ~crc[0];
      all.push_back(crc[15:8]);
      all.push_back(crc[7:0]);
      tx_byte(8'h00);
      tx_byte(8'h00);
      tx_byte(8'h16);
      check("rx_active_busy", 32'(rx_active), 32'd1);
      for (int k = 0; k < all.size(); k++) begin
         if (limit >= 0 && k >= limit) break;
         tx_byte(all[k]);
      end
      mlvds_ro = 3'b000;
   endtask

   // Full frame with expectations derived from address and CRC rules
   task automatic frame_test(input u8_t addr, input bit flip, input string tag);
      int d0, c0, ed, ec;
      bit aok;
      aok = (addr[7:5] == 3'd0) && ((addr[4:0] == mcb_addr) || (addr[4:0] == 5'h1F));
      ed = 0;
      ec = 0;
      if (!aok)     ed = 1;
      else if (flip) ec = 1;
      else begin
         foreach (tx_pl[k]) exp_q.push_back(tx_pl[k]);
         if (tx_pl.size() > 0) run_q.push_back(tx_pl.size());
      end
      d0 = n_drop;
      c0 = n_crc;
      send_frame(addr, 16'(tx_pl.size() + 1), flip, -1);
      repeat (40) @(negedge c);
      check({tag, "_drop"},      32'(n_drop - d0), 32'(ed));
      check({tag, "_crc_err"},   32'(n_crc - c0),  32'(ec));
      check({tag, "_pending"},   32'(exp_q.size()), 32'd0);
      check({tag, "_rx_active"}, 32'(rx_active),  32'd0);
   endtask

   task automatic rand_payload(input int n);
      tx_pl = {};
      for (int i = 0; i < n; i++) tx_pl.push_back(u8_t'($urandom));
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int  d0, c0;
      u8_t a;
      rst_n    = 1'b0;
      mcb_addr = 5'd3;
      mlvds_ro = 3'b000;
      repeat (4) @(negedge c);
      check("reset_rxd",       32'(rxd),       32'd0);
      check("reset_rxdv",      32'(rxdv),      32'd0);
      check("reset_rx_active", 32'(rx_active), 32'd0);
      check("reset_crc_err",   32'(crc_err),   32'd0);
      check("reset_drop",      32'(drop),      32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge c);

      tx_pl = {8'hA5, 8'h01, 8'hFF};
      frame_test(8'h03, 1'b0, "basic");
      frame_test(8'h03, 1'b1, "crc_flip");
      frame_test(8'h05, 1'b0, "addr_miss");
      frame_test(8'h1F, 1'b0, "bcast");
      frame_test(8'h03, 1'b0, "after_err");

      // Bit clock stalls mid-payload
      rand_payload(6);
      d0 = n_drop;
      c0 = n_crc;
      send_frame(8'h03, 16'd7, 1'b0, 5);
      repeat (90) @(negedge c);
      check("stall_drop",      32'(n_drop - d0), 32'd1);
      check("stall_crc_err",   32'(n_crc - c0),  32'd0);
      check("stall_rx_active", 32'(rx_active),   32'd0);
      rand_payload(4);
      frame_test(8'h03, 1'b0, "post_stall");

      // Illegal lengths are rejected as soon as LEN_LO arrives
      tx_pl = {};
      d0 = n_drop;
      send_frame(8'h03, 16'h0201, 1'b0, 2);
      repeat (40) @(negedge c);
      check("len_big_drop",      32'(n_drop - d0), 32'd1);
      check("len_big_rx_active", 32'(rx_active),   32'd0);
      d0 = n_drop;
      send_frame(8'h03, 16'h0000, 1'b0, 2);
      repeat (40) @(negedge c);
      check("len_zero_drop", 32'(n_drop - d0), 32'd1);
      tx_pl = {};
      frame_test(8'h03, 1'b0, "empty");

      // Reset asserted while payload is arriving
      rand_payload(5);
      send_frame(8'h03, 16'd6, 1'b0, 5);
      rst_n = 1'b0;
      #1;
      check("midrst_rxd",       32'(rxd),       32'd0);
      check("midrst_rxdv",      32'(rxdv),      32'd0);
      check("midrst_rx_active", 32'(rx_active), 32'd0);
      check("midrst_crc_err",   32'(crc_err),   32'd0);
      check("midrst_drop",      32'(drop),      32'd0);
      repeat (3) @(negedge c);
      rst_n = 1'b1;
      repeat (10) @(negedge c);
      rand_payload(3);
      frame_test(8'h03, 1'b0, "post_rst");

      // Randomized frames
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(4, 0))
            0:       a = 8'h03;
            1:       a = 8'h1F;
            2:       a = 8'h05;
            3:       a = 8'h23;
            default: a = 8'h03;
         endcase
         rand_payload(int'($urandom_range(8, 0)));
         frame_test(a, ($urandom_range(3, 0) == 0), "rand");
      end

      check("final_exp_q", 32'(exp_q.size()), 32'd0);
      check("final_run_q", 32'(run_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
